// File: rtl/uart_rx_core.sv
// ---------------------------------------------------------------------------
// uart_rx_core
//   UART receive engine. Synchronises the asynchronous serial line into the
//   uart_clk domain and oversamples it OVS times per bit. Each bit value is a
//   2-of-3 majority vote taken around mid-bit. Frames are 8N1, or 8 data bits
//   plus a 9th bit that is either even parity or raw data. Every completed
//   character loads a one-deep receive buffer and updates sticky status flags.
//
// Ports
//   uart_clk    in   1   block clock
//   sys_rstn    in   1   asynchronous active-low reset
//   uart_en     in   1   receiver enable; low aborts any frame in progress
//   uart_baud   in   16  tick divider; one tick every uart_baud+1 clocks
//   prty_en     in   1   frame carries a 9th bit after the data byte
//   prty_9bit   in   1   0: 9th bit is even parity and is checked; 1: raw data
//   uart_rx     in   1   asynchronous serial input, idle high
//   rxpnd_clr   in   1   pulse: clear rx_pnd and every error flag
//   rxbuf_rd    in   1   pulse: buffer was read; clears rx_pnd only
//   rx_data     out  8   receive buffer, LSB received first
//   rx_bit9     out  1   9th bit of the buffered character
//   rx_pnd      out  1   buffer holds an unread character
//   rx_perr     out  1   sticky parity error
//   rx_ferr     out  1   sticky frame error (stop bit sampled low)
//   rx_ovr      out  1   sticky overrun (character completed while rx_pnd=1)
//   rx_busy     out  1   receiver is inside a frame
//
// Handshake: rxpnd_clr and rxbuf_rd are single-cycle strobes with no
// back-pressure. A flag that is set and cleared in the same cycle ends up set.
// ---------------------------------------------------------------------------
module uart_rx_core #(
    parameter int OVS = 16
) (
    input  logic        uart_clk,
    input  logic        sys_rstn,
    input  logic        uart_en,
    input  logic [15:0] uart_baud,
    input  logic        prty_en,
    input  logic        prty_9bit,
    input  logic        uart_rx,
    input  logic        rxpnd_clr,
    input  logic        rxbuf_rd,
    output logic [7:0]  rx_data,
    output logic        rx_bit9,
    output logic        rx_pnd,
    output logic        rx_perr,
    output logic        rx_ferr,
    output logic        rx_ovr,
    output logic        rx_busy
);

    localparam int SW = $clog2(OVS);
    localparam logic [SW-1:0] SAMP_LO  = SW'(OVS / 2 - 1);
    localparam logic [SW-1:0] SAMP_MID = SW'(OVS / 2);
    localparam logic [SW-1:0] SAMP_HI  = SW'(OVS / 2 + 1);
    localparam logic [SW-1:0] SAMP_END = SW'(OVS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            rx_meta;
    logic            rx_s;
    logic            rx_s_d;
    logic            fall;

    logic [15:0]     baud_cnt;
    logic [SW-1:0]   samp_cnt;
    logic            tick;
    logic            decide;
    logic            bit_end;

    logic            samp_lo;
    logic            samp_mid;
    logic            maj;

    logic [2:0]      bitcnt;
    logic [7:0]      shreg;
    logic            bit9;
    logic            perr_pend;

    logic            done;
    logic            load;

    // -----------------------------------------------------------------------
    // Two-flop synchroniser plus one delay stage for falling-edge detection.
    // These keep running while disabled so that a line already low at
    // re-enable does not look like a fresh start bit.
    // -----------------------------------------------------------------------
    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_s_d  <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_s_d  <= rx_s;
        end
    end

    assign fall = rx_s_d & ~rx_s;

    // Ticks only matter inside a frame; the counters are held at zero in IDLE
    // so that the first tick of a frame is phase-aligned to the start edge.
    assign tick    = (state != IDLE) && (baud_cnt == uart_baud);
    assign decide  = tick && (samp_cnt == SAMP_HI);
    assign bit_end = tick && (samp_cnt == SAMP_END);

    // The third vote is the live line value on the decision tick.
    assign maj = (samp_lo & samp_mid) | (samp_lo & rx_s) | (samp_mid & rx_s);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and frame-completion strobe
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                end
            end
            START: begin
                // A start bit that votes high was a glitch.
                if (decide && maj) begin
                    state_nxt = IDLE;
                end else if (bit_end) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end && (bitcnt == 3'd7)) begin
                    state_nxt = prty_en ? PAR : STOP;
                end
            end
            PAR: begin
                if (bit_end) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                // Finish at mid-stop so a back-to-back start edge is not missed.
                if (decide) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (!uart_en) begin
            state_nxt = IDLE;
            done      = 1'b0;
        end
    end

    assign rx_busy = (state != IDLE);

    // -----------------------------------------------------------------------
    // Counters, sampling and shift register
    // -----------------------------------------------------------------------
    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            baud_cnt  <= '0;
            samp_cnt  <= '0;
            samp_lo   <= 1'b0;
            samp_mid  <= 1'b0;
            bitcnt    <= '0;
            shreg     <= '0;
            bit9      <= 1'b0;
            perr_pend <= 1'b0;
        end else if (!uart_en) begin
            baud_cnt  <= '0;
            samp_cnt  <= '0;
            samp_lo   <= 1'b0;
            samp_mid  <= 1'b0;
            bitcnt    <= '0;
            shreg     <= '0;
            bit9      <= 1'b0;
            perr_pend <= 1'b0;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            samp_cnt <= '0;
            if (fall) begin
                bitcnt    <= '0;
                bit9      <= 1'b0;
                perr_pend <= 1'b0;
            end
        end else begin
            if (tick) begin
                baud_cnt <= '0;
                samp_cnt <= (samp_cnt == SAMP_END) ? '0 : samp_cnt + 1'b1;
            end else begin
                baud_cnt <= baud_cnt + 16'd1;
            end

            if (tick && (samp_cnt == SAMP_LO)) begin
                samp_lo <= rx_s;
            end
            if (tick && (samp_cnt == SAMP_MID)) begin
                samp_mid <= rx_s;
            end

            if (decide && (state == DATA)) begin
                shreg <= {maj, shreg[7:1]};
            end
            if (decide && (state == PAR)) begin
                bit9      <= maj;
                perr_pend <= ~prty_9bit & (^{shreg, maj});
            end

            if (bit_end && (state == DATA)) begin
                bitcnt <= bitcnt + 3'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Receive buffer and sticky flags. Sets take priority over clears.
    // A frame error still loads the buffer so a break reads back as 0x00.
    // -----------------------------------------------------------------------
    assign load = done & ~rx_pnd;

    always_ff @(posedge uart_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            rx_data <= '0;
            rx_bit9 <= 1'b0;
            rx_pnd  <= 1'b0;
            rx_perr <= 1'b0;
            rx_ferr <= 1'b0;
            rx_ovr  <= 1'b0;
        end else begin
            if (load) begin
                rx_data <= shreg;
                rx_bit9 <= bit9;
            end

            if (load) begin
                rx_pnd <= 1'b1;
            end else if (rxpnd_clr || rxbuf_rd) begin
                rx_pnd <= 1'b0;
            end

            if (load && perr_pend) begin
                rx_perr <= 1'b1;
            end else if (rxpnd_clr) begin
                rx_perr <= 1'b0;
            end

            if (load && !maj) begin
                rx_ferr <= 1'b1;
            end else if (rxpnd_clr) begin
                rx_ferr <= 1'b0;
            end

            if (done && rx_pnd) begin
                rx_ovr <= 1'b1;
            end else if (rxpnd_clr) begin
                rx_ovr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_core
//   Self-checking bench for uart_rx_core. Frames are driven bit-serially on
//   uart_rx. A character-level model tracks what the receive buffer and flags
//   must hold after every frame, read and clear. A compare process checks
//   every output against the model on each cycle while the receiver is
//   expected to be quiet. Literal checks pin the directed cases.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_uart_rx_core;

    // ---------------- clock / reset ----------------
    logic        uart_clk = 1'b0;
    logic        sys_rstn;
    logic        uart_en;
    logic [15:0] uart_baud;
    logic        prty_en;
    logic        prty_9bit;
    logic        uart_rx;
    logic        rxpnd_clr;
    logic        rxbuf_rd;
    logic [7:0]  rx_data;
    logic        rx_bit9;
    logic        rx_pnd;
    logic        rx_perr;
    logic        rx_ferr;
    logic        rx_ovr;
    logic        rx_busy;

    always #5 uart_clk = ~uart_clk;

    uart_rx_core #(.OVS(16)) dut (
        .uart_clk  (uart_clk),
        .sys_rstn  (sys_rstn),
        .uart_en   (uart_en),
        .uart_baud (uart_baud),
        .prty_en   (prty_en),
        .prty_9bit (prty_9bit),
        .uart_rx   (uart_rx),
        .rxpnd_clr (rxpnd_clr),
        .rxbuf_rd  (rxbuf_rd),
        .rx_data   (rx_data),
        .rx_bit9   (rx_bit9),
        .rx_pnd    (rx_pnd),
        .rx_perr   (rx_perr),
        .rx_ferr   (rx_ferr),
        .rx_ovr    (rx_ovr),
        .rx_busy   (rx_busy)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    logic [7:0] m_data;
    logic       m_bit9;
    logic       m_pnd;
    logic       m_perr;
    logic       m_ferr;
    logic       m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    task automatic model_reset();
        m_data = 8'h00;
        m_bit9 = 1'b0;
        m_pnd  = 1'b0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
    endtask

    // One received character: buffer loads if empty, otherwise it is dropped
    // and overrun is flagged.
    task automatic model_frame(input logic [7:0] d, input logic b9, input logic stop);
        logic b;
        logic bad_par;
        b       = prty_en ? b9 : 1'b0;
        bad_par = prty_en & ~prty_9bit & ((^d) ^ b9);
        if (!m_pnd) begin
            m_data = d;
            m_bit9 = b;
            m_pnd  = 1'b1;
            if (bad_par) m_perr = 1'b1;
            if (!stop)   m_ferr = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
    endtask

    // ---------------- compare process ----------------
    always @(posedge uart_clk) begin
        #2;
        if (chk_en) begin
            check("cmp_rx_data", rx_data, m_data);
            check("cmp_rx_bit9", rx_bit9, m_bit9);
            check("cmp_rx_pnd",  rx_pnd,  m_pnd);
            check("cmp_rx_perr", rx_perr, m_perr);
            check("cmp_rx_ferr", rx_ferr, m_ferr);
            check("cmp_rx_ovr",  rx_ovr,  m_ovr);
            check("cmp_rx_busy", rx_busy, 1'b0);
        end
    end

    // ---------------- driver tasks (called at a negedge, return at a negedge) ----------------
    // gbit selects a frame bit (0=start) that gets a one-clock inverted
    // glitch at its centre; -1 for none. upd=0 leaves the model untouched.
    task automatic send_frame(input logic [7:0] d, input logic b9, input logic stop,
                              input int gap, input int gbit, input bit upd);
        logic bits[$];
        int   len;
        chk_en = 1'b0;
        len    = 16 * (int'(uart_baud) + 1);
        bits.push_back(1'b0);
        for (int k = 0; k < 8; k++) bits.push_back(d[k]);
        if (prty_en) bits.push_back(b9);
        bits.push_back(stop);
        for (int i = 0; i < bits.size(); i++) begin
            for (int c = 0; c < len; c++) begin
                uart_rx = (i == gbit && c == len / 2 + 1) ? ~bits[i] : bits[i];
                @(negedge uart_clk);
            end
        end
        uart_rx = 1'b1;
        if (upd) model_frame(d, b9, stop);
        chk_en = 1'b1;
        repeat (gap) @(negedge uart_clk);
    endtask

    task automatic pulse_rd();
        chk_en   = 1'b0;
        rxbuf_rd = 1'b1;
        @(negedge uart_clk);
        rxbuf_rd = 1'b0;
        m_pnd    = 1'b0;
        chk_en   = 1'b1;
        @(negedge uart_clk);
    endtask

    task automatic pulse_clr();
        chk_en    = 1'b0;
        rxpnd_clr = 1'b1;
        @(negedge uart_clk);
        rxpnd_clr = 1'b0;
        m_pnd     = 1'b0;
        m_perr    = 1'b0;
        m_ferr    = 1'b0;
        m_ovr     = 1'b0;
        chk_en    = 1'b1;
        @(negedge uart_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, rx_data, 8'h00);
        check({tag, "_bit9"}, rx_bit9, 1'b0);
        check({tag, "_pnd"},  rx_pnd,  1'b0);
        check({tag, "_perr"}, rx_perr, 1'b0);
        check({tag, "_ferr"}, rx_ferr, 1'b0);
        check({tag, "_ovr"},  rx_ovr,  1'b0);
        check({tag, "_busy"}, rx_busy, 1'b0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main stimulus ----------------
    initial begin
        int lat;
        sys_rstn  = 1'b0;
        uart_en   = 1'b1;
        uart_baud = 16'd0;
        prty_en   = 1'b0;
        prty_9bit = 1'b0;
        uart_rx   = 1'b1;
        rxpnd_clr = 1'b0;
        rxbuf_rd  = 1'b0;
        model_reset();
        repeat (3) @(negedge uart_clk);
        check_all_zero("reset");
        sys_rstn = 1'b1;
        repeat (4) @(negedge uart_clk);
        chk_en = 1'b1;

        // 1: 8N1 0x55 at 16-clock bits, with fall-to-pending latency
        lat = -1;
        fork
            send_frame(8'h55, 1'b0, 1'b1, 8, -1, 1'b1);
            begin
                for (int c = 1; c <= 300; c++) begin
                    @(posedge uart_clk);
                    #2;
                    if (rx_pnd === 1'b1) begin
                        lat = c;
                        break;
                    end
                end
            end
        join
        check("t1_latency_150_158", (lat >= 150 && lat <= 158), 1'b1);
        check("t1_data", rx_data, 8'h55);
        check("t1_pnd",  rx_pnd,  1'b1);
        check("t1_errs", {rx_perr, rx_ferr, rx_ovr}, 3'b000);
        pulse_rd();

        // 2: even parity, good then bad
        prty_en   = 1'b1;
        prty_9bit = 1'b0;
        send_frame(8'hA3, 1'b0, 1'b1, 8, -1, 1'b1);
        check("t2_good_pnd",  rx_pnd,  1'b1);
        check("t2_good_perr", rx_perr, 1'b0);
        pulse_rd();
        send_frame(8'hA3, 1'b1, 1'b1, 8, -1, 1'b1);
        check("t2_bad_perr", rx_perr, 1'b1);
        check("t2_bad_data", rx_data, 8'hA3);
        check("t2_bad_bit9", rx_bit9, 1'b1);
        pulse_clr();
        prty_en = 1'b0;

        // 3: break character with stop bit low
        send_frame(8'h00, 1'b0, 1'b0, 8, -1, 1'b1);
        check("t3_ferr", rx_ferr, 1'b1);
        check("t3_data", rx_data, 8'h00);
        check("t3_pnd",  rx_pnd,  1'b1);
        pulse_clr();
        check("t3_clr_flags", {rx_pnd, rx_perr, rx_ferr, rx_ovr}, 4'b0000);

        // 4: overrun
        send_frame(8'h11, 1'b0, 1'b1, 0, -1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1, 8, -1, 1'b1);
        check("t4_keep_data", rx_data, 8'h11);
        check("t4_ovr",       rx_ovr,  1'b1);
        pulse_rd();
        send_frame(8'h33, 1'b0, 1'b1, 8, -1, 1'b1);
        check("t4_new_data",  rx_data, 8'h33);
        check("t4_ovr_stick", rx_ovr,  1'b1);
        pulse_clr();
        pulse_rd();

        // 5: idle-line glitch, then a mid-sample glitch inside a data bit
        chk_en  = 1'b0;
        uart_rx = 1'b0;
        repeat (4) @(negedge uart_clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge uart_clk);
        chk_en = 1'b1;
        check("t5_glitch_busy", rx_busy, 1'b0);
        check("t5_glitch_pnd",  rx_pnd,  1'b0);
        send_frame(8'h96, 1'b0, 1'b1, 8, 4, 1'b1);
        check("t5_maj_data", rx_data, 8'h96);
        pulse_rd();

        // 6a: disable mid-DATA with the line held low, then re-enable
        fork
            send_frame(8'h00, 1'b0, 1'b1, 8, -1, 1'b0);
            begin
                repeat (16 * 3 + 8) @(negedge uart_clk);
                check("t6_busy_before_dis", rx_busy, 1'b1);
                uart_en = 1'b0;
                @(negedge uart_clk);
                check("t6_dis_busy", rx_busy, 1'b0);
                repeat (2) @(negedge uart_clk);
                uart_en = 1'b1;
            end
        join
        check("t6_en_busy",  rx_busy, 1'b0);
        check("t6_en_flags", {rx_pnd, rx_perr, rx_ferr, rx_ovr}, 4'b0000);

        // random traffic
        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            logic       b9;
            logic       stop;
            int         op;
            uart_baud = 16'($urandom_range(0, 2));
            prty_en   = 1'($urandom_range(0, 1));
            prty_9bit = 1'($urandom_range(0, 1));
            d         = 8'($urandom_range(0, 255));
            b9        = 1'($urandom_range(0, 1));
            stop      = ($urandom_range(0, 7) != 0);
            send_frame(d, b9, stop, $urandom_range(4, 20), -1, 1'b1);
            op = $urandom_range(0, 3);
            if (op == 1) pulse_rd();
            else if (op == 2) pulse_clr();
        end
        uart_baud = 16'd0;
        prty_en   = 1'b0;
        prty_9bit = 1'b0;
        pulse_clr();

        // 6b: reset in the middle of a frame, then a clean frame
        send_frame(8'h5A, 1'b0, 1'b0, 8, -1, 1'b1);
        check("t6_pre_pnd",  rx_pnd,  1'b1);
        check("t6_pre_ferr", rx_ferr, 1'b1);
        chk_en  = 1'b0;
        uart_rx = 1'b0;
        repeat (40) @(negedge uart_clk);
        check("t6_midframe_busy", rx_busy, 1'b1);
        sys_rstn = 1'b0;
        @(negedge uart_clk);
        uart_rx = 1'b1;
        check_all_zero("t6_rst");
        model_reset();
        repeat (2) @(negedge uart_clk);
        sys_rstn = 1'b1;
        repeat (4) @(negedge uart_clk);
        chk_en = 1'b1;
        send_frame(8'hC7, 1'b0, 1'b1, 8, -1, 1'b1);
        check("t6_clean_data", rx_data, 8'hC7);
        check("t6_clean_pnd",  rx_pnd,  1'b1);
        check("t6_clean_errs", {rx_perr, rx_ferr, rx_ovr}, 3'b000);

        chk_en = 1'b0;
        @(negedge uart_clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
